// File: rtl/scan_layer_scheduler.sv
// Layer sequencer and tile-fetch scheduler for the column scanner.
// Optional stall counter is built when SCAN_SCHED_STALL_CNT_EN is defined.
module scan_layer_scheduler #(
   parameter int NUM_LAYERS = 8,
   parameter int OUT_H      = 112,
   parameter int TILE_H     = 6,
   parameter int K          = 3,
   localparam int AW        = $clog2(NUM_LAYERS),
   localparam int RW        = $clog2(OUT_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_wr_en,
   input  logic [AW-1:0] cfg_wr_addr,
   input  logic [16:0]   cfg_wr_data,
   input  logic          run,
   input  logic [AW:0]   num_layers,
   output logic [7:0]    scan_cfg_w,
   output logic [7:0]    scan_cfg_h,
   output logic          scan_stride2_en,
   output logic          scan_start,
   input  logic          scan_tile_start,
   input  logic [RW-1:0] scan_tile_row,
   input  logic          scan_done,
   output logic          buffer_ready,
   output logic          fetch_req,
   output logic [RW-1:0] fetch_row,
   input  logic          fetch_ack,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] layer_idx,
   output logic          err_overrun,
   output logic [31:0]   stall_cycles,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_FIN} state_t;

   localparam int            STEP_I = TILE_H - K + 1;
   localparam logic [RW-1:0] STEP1  = RW'(STEP_I);
   localparam logic [RW-1:0] STEP2  = RW'(2 * STEP_I);
   localparam logic [AW:0]   MAX_NL = (AW+1)'(NUM_LAYERS);

   logic [16:0] tbl [NUM_LAYERS];
   logic [16:0] entry;

   state_t        state_q, state_d;
   logic [AW-1:0] layer_idx_q, layer_idx_d;
   logic [AW:0]   num_q, num_d;
   logic [7:0]    cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
   logic          cfg_s2_q, cfg_s2_d;
   logic          scan_start_q, scan_start_d;
   logic          fetch_req_q, fetch_req_d;
   logic [RW-1:0] fetch_row_q, fetch_row_d;
   logic          outst_q, outst_d, pend_q, pend_d;
   logic [1:0]    ready_q, ready_d;
   logic [RW-1:0] next_row_q, next_row_d, row_seen_q, row_seen_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic          ack_ok, consume, overrun, want;
   logic [RW-1:0] step;

   // Table has no reset so its contents survive rst_n; writes are blocked while busy.
   always_ff @(posedge clk) begin
      if (cfg_wr_en && !busy_q) tbl[cfg_wr_addr] <= cfg_wr_data;
   end

   assign entry   = tbl[layer_idx_q];
   assign step    = cfg_s2_q ? STEP2 : STEP1;
   assign ack_ok  = fetch_ack && outst_q;
   assign consume = (scan_tile_row != row_seen_q);
   assign overrun = scan_tile_start && (pend_q || (ready_q == 2'd2));
   assign want    = pend_q || (scan_tile_start && !overrun);

   // Loader handshake: fetch_req is a level held from issue until the one-cycle
   // fetch_ack; an ack with no fetch outstanding is ignored.
   always_comb begin
      state_d      = state_q;
      layer_idx_d  = layer_idx_q;
      num_d        = num_q;
      cfg_w_d      = cfg_w_q;
      cfg_h_d      = cfg_h_q;
      cfg_s2_d     = cfg_s2_q;
      scan_start_d = 1'b0;
      fetch_req_d  = fetch_req_q;
      fetch_row_d  = fetch_row_q;
      outst_d      = outst_q;
      pend_d       = pend_q;
      ready_d      = ready_q;
      next_row_d   = next_row_q;
      row_seen_d   = scan_tile_row;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               err_d = 1'b0;
               if (num_layers == '0) begin
                  done_d = 1'b1;
               end else begin
                  layer_idx_d = '0;
                  num_d       = (num_layers > MAX_NL) ? MAX_NL : num_layers;
                  busy_d      = 1'b1;
                  state_d     = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cfg_w_d     = entry[7:0];
            cfg_h_d     = entry[15:8];
            cfg_s2_d    = entry[16];
            ready_d     = 2'd0;
            pend_d      = 1'b0;
            outst_d     = 1'b0;
            fetch_req_d = 1'b0;
            next_row_d  = '0;
            if (entry[7:0] == 8'd0 || entry[15:8] == 8'd0) begin
               state_d = S_NEXT;
            end else begin
               scan_start_d = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            if (overrun) err_d = 1'b1;
            if (scan_done) begin
               fetch_req_d = 1'b0;
               outst_d     = 1'b0;
               pend_d      = 1'b0;
               state_d     = S_NEXT;
            end else begin
               pend_d = want;
               if (want && !outst_q && ready_q != 2'd2) begin
                  fetch_req_d = 1'b1;
                  fetch_row_d = next_row_q;
                  outst_d     = 1'b1;
                  pend_d      = 1'b0;
                  next_row_d  = next_row_q + step;
               end
               if (ack_ok) begin
                  fetch_req_d = 1'b0;
                  outst_d     = 1'b0;
               end
               case ({ack_ok, consume})
                  2'b10:   if (ready_q != 2'd2) ready_d = ready_q + 2'd1;
                  2'b01:   if (ready_q != 2'd0) ready_d = ready_q - 2'd1;
                  default: ready_d = ready_q;
               endcase
            end
         end
         S_NEXT: begin
            layer_idx_d = layer_idx_q + AW'(1);
            if ((AW+1)'(layer_idx_q) + (AW+1)'(1) == num_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_FIN;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         layer_idx_q  <= '0;
         num_q        <= '0;
         cfg_w_q      <= '0;
         cfg_h_q      <= '0;
         cfg_s2_q     <= 1'b0;
         scan_start_q <= 1'b0;
         fetch_req_q  <= 1'b0;
         fetch_row_q  <= '0;
         outst_q      <= 1'b0;
         pend_q       <= 1'b0;
         ready_q      <= 2'd0;
         next_row_q   <= '0;
         row_seen_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         layer_idx_q  <= layer_idx_d;
         num_q        <= num_d;
         cfg_w_q      <= cfg_w_d;
         cfg_h_q      <= cfg_h_d;
         cfg_s2_q     <= cfg_s2_d;
         scan_start_q <= scan_start_d;
         fetch_req_q  <= fetch_req_d;
         fetch_row_q  <= fetch_row_d;
         outst_q      <= outst_d;
         pend_q       <= pend_d;
         ready_q      <= ready_d;
         next_row_q   <= next_row_d;
         row_seen_q   <= row_seen_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign buffer_ready    = (state_q == S_RUN) && (ready_q != 2'd0);
   assign scan_cfg_w      = cfg_w_q;
   assign scan_cfg_h      = cfg_h_q;
   assign scan_stride2_en = cfg_s2_q;
   assign scan_start      = scan_start_q;
   assign fetch_req       = fetch_req_q;
   assign fetch_row       = fetch_row_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign layer_idx       = layer_idx_q;
   assign err_overrun     = err_q;
   assign state_dbg       = state_q;

`ifdef SCAN_SCHED_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == S_IDLE && run) begin
         stall_d = '0;
      end else if (state_q == S_RUN && !buffer_ready && stall_q != 32'hFFFF_FFFF) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_scan_layer_scheduler.sv
// Directed bench for scan_layer_scheduler: table-driven single-layer runs
// followed by hand-written multi-cycle corner sequences.
module tb_scan_layer_scheduler;
   localparam int AW = 3;
   localparam int RW = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_wr_en;
   logic [AW-1:0] cfg_wr_addr;
   logic [16:0]   cfg_wr_data;
   logic          run;
   logic [AW:0]   num_layers;
   logic [7:0]    scan_cfg_w, scan_cfg_h;
   logic          scan_stride2_en, scan_start;
   logic          scan_tile_start;
   logic [RW-1:0] scan_tile_row;
   logic          scan_done, buffer_ready, fetch_req;
   logic [RW-1:0] fetch_row;
   logic          fetch_ack, busy, done;
   logic [AW-1:0] layer_idx;
   logic          err_overrun;
   logic [31:0]   stall_cycles;
   logic [2:0]    state_dbg;

   scan_layer_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .run(run), .num_layers(num_layers),
      .scan_cfg_w(scan_cfg_w), .scan_cfg_h(scan_cfg_h), .scan_stride2_en(scan_stride2_en),
      .scan_start(scan_start), .scan_tile_start(scan_tile_start), .scan_tile_row(scan_tile_row),
      .scan_done(scan_done), .buffer_ready(buffer_ready),
      .fetch_req(fetch_req), .fetch_row(fetch_row), .fetch_ack(fetch_ack),
      .busy(busy), .done(done), .layer_idx(layer_idx), .err_overrun(err_overrun),
      .stall_cycles(stall_cycles), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]              w;
      logic [7:0]              h;
      logic                    s2;
      int                      nt;
      logic [2:0][RW-1:0]      rows;
   } vec_t;

   vec_t          vecs[4];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [RW-1:0] tile_row_v = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cfg(input logic [AW-1:0] a, input logic s2, input logic [7:0] h, input logic [7:0] w);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = a;
      cfg_wr_data = {s2, h, w};
      tick();
      cfg_wr_en   = 1'b0;
   endtask

   task automatic start_run(input logic [AW:0] n);
      num_layers = n;
      run        = 1'b1;
      tick();
      run        = 1'b0;
   endtask

   task automatic do_tile(input logic [RW-1:0] exp_row);
      scan_tile_start = 1'b1;
      tick();
      scan_tile_start = 1'b0;
      chk("tile_fetch_req", fetch_req, 1);
      chk("tile_fetch_row", fetch_row, exp_row);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      chk("tile_req_drop", fetch_req, 0);
      chk("tile_buf_ready", buffer_ready, 1);
      tile_row_v    = tile_row_v + 7'd1;
      scan_tile_row = tile_row_v;
      tick();
      chk("tile_consumed", buffer_ready, 0);
   endtask

   task automatic end_layer_last();
      scan_done = 1'b1;
      tick();
      scan_done = 1'b0;
      chk("done_not_early", done, 0);
      tick();
      chk("done_pulse", done, 1);
      chk("busy_fin", busy, 0);
      tick();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s0;
      logic        bp_ok;

      vecs[0] = '{w: 8'd8,   h: 8'd8,   s2: 1'b0, nt: 2, rows: {7'd8,  7'd4, 7'd0}};
      vecs[1] = '{w: 8'd10,  h: 8'd20,  s2: 1'b1, nt: 3, rows: {7'd16, 7'd8, 7'd0}};
      vecs[2] = '{w: 8'd16,  h: 8'd12,  s2: 1'b0, nt: 3, rows: {7'd8,  7'd4, 7'd0}};
      vecs[3] = '{w: 8'd255, h: 8'd255, s2: 1'b1, nt: 3, rows: {7'd16, 7'd8, 7'd0}};

      rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      run = 1'b0; num_layers = '0; scan_tile_start = 1'b0; scan_tile_row = '0;
      scan_done = 1'b0; fetch_ack = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_scan_start", scan_start, 0);
      chk("rst_cfg", {scan_cfg_w, scan_cfg_h, 7'd0, scan_stride2_en}, 0);
      chk("rst_err", err_overrun, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_state", state_dbg, 0);
      rst_n = 1'b1;
      tick();

      // Table-driven single-layer runs.
      for (int i = 0; i < 4; i++) begin
         wr_cfg(0, vecs[i].s2, vecs[i].h, vecs[i].w);
         start_run(1);
         chk("v_busy", busy, 1);
         chk("v_start_early", scan_start, 0);
         tick();
         chk("v_scan_start", scan_start, 1);
         chk("v_cfg_w", scan_cfg_w, vecs[i].w);
         chk("v_cfg_h", scan_cfg_h, vecs[i].h);
         chk("v_cfg_s2", scan_stride2_en, vecs[i].s2);
         tick();
         chk("v_start_pulse", scan_start, 0);
         for (int j = 0; j < vecs[i].nt; j++) do_tile(vecs[i].rows[j]);
         end_layer_last();
      end

      // Two layers: stride 1 then stride 2.
      wr_cfg(0, 1'b0, 8'd8, 8'd8);
      wr_cfg(1, 1'b1, 8'd20, 8'd10);
      start_run(2);
      tick();
      chk("two_l0_start", scan_start, 1);
      chk("two_l0_s2", scan_stride2_en, 0);
      tick();
      do_tile(7'd0);
      scan_done = 1'b1;
      tick();
      scan_done = 1'b0;
      chk("two_next_idx", layer_idx, 0);
      tick();
      chk("two_load_idx", layer_idx, 1);
      chk("two_load_nostart", scan_start, 0);
      chk("two_load_s2_hold", scan_stride2_en, 0);
      tick();
      chk("two_l1_start", scan_start, 1);
      chk("two_l1_s2", scan_stride2_en, 1);
      chk("two_l1_h", scan_cfg_h, 20);
      chk("two_busy_mid", busy, 1);
      tick();
      do_tile(7'd0);
      do_tile(7'd8);
      do_tile(7'd16);
      end_layer_last();

      // Backpressure: ack held off for 10 cycles.
      start_run(1);
      tick(); tick();
      scan_tile_start = 1'b1;
      tick();
      scan_tile_start = 1'b0;
      chk("bp_req", fetch_req, 1);
      s0    = stall_cycles;
      bp_ok = 1'b1;
      repeat (10) begin
         tick();
         if (buffer_ready !== 1'b0) bp_ok = 1'b0;
      end
      chk("bp_no_ready", bp_ok, 1);
      chk("bp_req_held", fetch_req, 1);
`ifdef SCAN_SCHED_STALL_CNT_EN
      chk("bp_stall_grow", (stall_cycles - s0) >= 32'd10, 1);
`else
      chk("bp_stall_zero", stall_cycles, 0);
`endif
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      chk("bp_ready", buffer_ready, 1);
      end_layer_last();

      // Overrun: tile_start while fetch outstanding and pend already set.
      start_run(1);
      tick(); tick();
      scan_tile_start = 1'b1;
      tick();
      chk("ovr_req", fetch_req, 1);
      tick();
      chk("ovr_pend_ok", err_overrun, 0);
      tick();
      scan_tile_start = 1'b0;
      chk("ovr_flag", err_overrun, 1);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      end_layer_last();
      chk("ovr_sticky", err_overrun, 1);

      // Skip layer with h=0, then a normal layer; run clears err.
      wr_cfg(0, 1'b0, 8'd0, 8'd8);
      wr_cfg(1, 1'b0, 8'd8, 8'd8);
      start_run(2);
      chk("run_clears_err", err_overrun, 0);
      chk("skip_idx0", layer_idx, 0);
      tick();
      chk("skip_no_start", scan_start, 0);
      tick();
      chk("skip_idx1", layer_idx, 1);
      chk("skip_no_start2", scan_start, 0);
      tick();
      chk("skip_l1_start", scan_start, 1);
      chk("skip_l1_h", scan_cfg_h, 8);
      end_layer_last();

      // num_layers = 0.
      start_run(0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_done_clr", done, 0);
      chk("zero_idle", state_dbg, 0);

      // Reset mid-RUN with a fetch outstanding.
      wr_cfg(0, 1'b1, 8'd16, 8'd12);
      start_run(1);
      tick(); tick();
      scan_tile_start = 1'b1;
      tick();
      scan_tile_start = 1'b0;
      chk("mr_req", fetch_req, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_req_clr", fetch_req, 0);
      chk("mr_busy_clr", busy, 0);
      chk("mr_cfg_clr", {scan_cfg_w, scan_cfg_h}, 0);
      tick();
      chk("mr_state", state_dbg, 0);
      chk("mr_s2_clr", scan_stride2_en, 0);
      rst_n = 1'b1;
      tick();
      start_run(1);
      tick();
      chk("mr_rerun_start", scan_start, 1);
      chk("mr_rerun_w", scan_cfg_w, 12);
      chk("mr_rerun_h", scan_cfg_h, 16);
      chk("mr_rerun_s2", scan_stride2_en, 1);
      tick();
      end_layer_last();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/scan_layer_scheduler.md
# scan_layer_scheduler

Layer-level sequencer and tile-fetch scheduler for the column scanner pipeline. It holds a small table of per-layer scan configurations and runs them in order. For each layer it configures and starts the column scanner, turns the scanner's `tile_start` prefetch pulses into tile fetch requests to the feature-map loader, and drives the scanner's `buffer_ready` from a double-buffer occupancy count. It sits between the top-level layer control and the scanner/loader pair.

## Interface
Parameters:
- `NUM_LAYERS`, default 8: layer table depth.
- `OUT_H`, default 112: maximum output height; sets the tile-row width `RW = $clog2(OUT_H)`.
- `TILE_H`, default 6: tile height.
- `K`, default 3: kernel size.
  - Row step is `TILE_H-K+1` (4) at stride 1.
  - Row step is `2*(TILE_H-K+1)` (8) at stride 2.

Ports:
- Clock and reset (one clock; reset is asynchronous and active-low):
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- Layer table write port:
  - `cfg_wr_en` in 1: table write strobe; ignored while `busy`.
  - `cfg_wr_addr` in `$clog2(NUM_LAYERS)`: table entry to write.
  - `cfg_wr_data` in 17: `{stride2, h[7:0], w[7:0]}`.
- Run control:
  - `run` in 1: start pulse; accepted only in IDLE.
  - `num_layers` in `$clog2(NUM_LAYERS)+1`: number of layers to run; sampled on `run`.
- Scanner configuration outputs (registered):
  - `scan_cfg_w` out 8.
  - `scan_cfg_h` out 8.
  - `scan_stride2_en` out 1.
- Scanner handshake:
  - `scan_start` out 1: one-cycle pulse that starts the scanner.
  - `scan_tile_start` in 1: prefetch request pulse from the scanner.
  - `scan_tile_row` in RW: scanner's current tile row.
  - `scan_done` in 1: scanner completion pulse.
  - `buffer_ready` out 1: tile data available to the scanner.
- Loader handshake:
  - `fetch_req` out 1: fetch request; level signal.
  - `fetch_row` out RW: first output row of the requested tile.
  - `fetch_ack` in 1: one-cycle pulse marking the tile written to the buffer.
- Status:
  - `busy` out 1.
  - `done` out 1: one-cycle pulse when all layers finish.
  - `layer_idx` out `$clog2(NUM_LAYERS)`: current layer.
  - `err_overrun` out 1: sticky error flag.
  - `stall_cycles` out 32: stall counter (see Configuration).

## Operation
State machine: IDLE → LOAD → RUN → NEXT → (LOAD | FIN) → IDLE.

- **IDLE**
  - `busy=0`.
  - On `run`:
    - If `num_layers==0`: pulse `done` next cycle and stay in IDLE.
    - Otherwise: `layer_idx←0`, `busy←1`, go to LOAD.
- **LOAD** (one cycle)
  - Register `scan_cfg_*` from `table[layer_idx]`.
  - Clear tile state: `ready_cnt←0`, `pend←0`, `outst←0`, `next_row←0`.
  - If the entry has `w==0` or `h==0`: skip the layer and go to NEXT without pulsing `scan_start`.
  - Otherwise: pulse `scan_start` and go to RUN.
- **RUN** (tile scheduling)
  - `scan_tile_start` sets `pend`. If `pend` is already set, or two fetches are already queued, set `err_overrun`. The pulse is dropped.
  - Fetch issue: when `pend && !outst && ready_cnt<2`:
    - `fetch_req←1`, `fetch_row←next_row`, `outst←1`, `pend←0`.
    - `next_row←next_row+step` (mod 2^RW).
  - `fetch_req` holds until `fetch_ack`. On `fetch_ack`: `fetch_req←0`, `outst←0`, `ready_cnt+1`.
  - Tile consumed: when `scan_tile_row` differs from its registered copy, `ready_cnt−1`.
    - A simultaneous `fetch_ack` and consumption leave `ready_cnt` unchanged.
    - `ready_cnt` saturates at 0 and 2.
  - `buffer_ready = (state==RUN) && ready_cnt!=0`. This is combinational from registers.
  - `scan_done` goes to NEXT. Any outstanding fetch is abandoned: `fetch_req←0` and a late `fetch_ack` is ignored.
- **NEXT**
  - `layer_idx+1`.
  - If the new index equals `num_layers`: go to FIN.
  - Otherwise: go to LOAD.
- **FIN**
  - Pulse `done`, `busy←0`, go to IDLE.
- `scan_cfg_*` holds its value after a layer until the next LOAD.

## Timing
- Reset values:
  - All outputs are 0.
  - `err_overrun=0`, `stall_cycles=0`, state=IDLE.
  - Table contents are not reset.
- `run` at cycle t gives LOAD at t+1. `scan_start` and the new `scan_cfg_*` values are both visible at t+2, so the configuration is valid when the scanner samples `start`.
- `scan_tile_start` at t gives `fetch_req` at t+1, if the issue conditions hold.
- `fetch_ack` at t gives `buffer_ready` high at t+1.
- `scan_done` at t: NEXT at t+1, LOAD at t+2, next `scan_start` at t+3.
- Reset asserted mid-operation immediately returns all state to reset values. Table contents are retained.
- A `run` received while `busy` is ignored.
- `err_overrun` clears only on `rst_n` or on an accepted `run`.

## Configuration
- `SCAN_SCHED_STALL_CNT_EN` defined:
  - `stall_cycles` counts cycles with state==RUN and `buffer_ready==0`.
  - The counter saturates at 2^32−1.
  - It clears on an accepted `run`.
- `SCAN_SCHED_STALL_CNT_EN` undefined:
  - `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Basic run.** Write layer 0 as w=8, h=8, stride 1; `run` with `num_layers=1`.
  - Expect `scan_start` 2 cycles after `run`.
  - The `tile_start` at start gives `fetch_req` with `fetch_row=0`. After `ack`, `buffer_ready=1`.
  - The second `tile_start` gives `fetch_row=4`.
  - `scan_done` gives a `done` pulse 2 cycles later.
- **Two layers.** Layer 0 stride 1, layer 1 stride 2 with h=20.
  - Layer 1 fetch rows are 0, 8, 16.
  - `scan_cfg_stride2_en` toggles to 1 in the cycle `scan_start` is pulsed for layer 1.
- **Backpressure.** Hold `fetch_ack` low for 10 cycles.
  - `buffer_ready` stays 0.
  - With the macro defined, `stall_cycles` increases by 10 or more.
- **Overrun.** Pulse `scan_tile_start` twice while a fetch is outstanding and `pend` is set.
  - `err_overrun=1` and stays set until the next `run`.
- **Skip and zero.**
  - A layer with h=0 produces no `scan_start` and `layer_idx` advances.
  - `num_layers=0` gives `done` one cycle after `run`, with no `busy`.
- **Reset mid-RUN.** Assert `rst_n=0` while `fetch_req=1`.
  - All outputs are 0 next cycle.
  - The table is preserved: rerunning gives identical `scan_cfg_*`.
